// File: rtl/mem_bus_arbiter.sv
// Byte-wide memory/IO bus arbiter: round-robin over CPU-side masters with burst lock,
// debug override, RAM/IO decode and read-data return after a fixed read latency.
module mem_bus_arbiter #(
  parameter int NUM_MASTERS  = 2,
  parameter int ADDR_WIDTH   = 17,
  parameter int IO_SEL_WIDTH = 3,
  parameter int READ_LATENCY = 1
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [NUM_MASTERS-1:0]    m_req,
  input  logic [NUM_MASTERS-1:0]    m_wr,
  input  logic [NUM_MASTERS-1:0]    m_lock,
  input  logic [32*NUM_MASTERS-1:0] m_a,
  input  logic [8*NUM_MASTERS-1:0]  m_dout,
  output logic [NUM_MASTERS-1:0]    m_gnt,
  output logic [NUM_MASTERS-1:0]    m_rvalid,
  output logic [7:0]                m_din,
  input  logic                      dbg_active,
  input  logic [31:0]               dbg_a,
  input  logic                      dbg_wr,
  input  logic [7:0]                dbg_dout,
  output logic [7:0]                dbg_din,
  output logic                      ram_en,
  output logic                      ram_r_nw,
  output logic [ADDR_WIDTH-1:0]     ram_a,
  output logic [7:0]                ram_d_out,
  input  logic [7:0]                ram_din,
  output logic                      io_en,
  output logic [IO_SEL_WIDTH-1:0]   io_sel,
  output logic                      io_wr,
  output logic [7:0]                io_dout,
  input  logic [7:0]                io_din
);

  localparam int PTR_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]       lock_owner_q, lock_owner_d;
  logic                   lock_valid_q, lock_valid_d;
  logic                   lock_hit_s;
  logic [NUM_MASTERS-1:0] rr_gnt_s;
  logic [NUM_MASTERS-1:0] gnt_s;
  logic [PTR_W-1:0]       gnt_idx_s;
  logic [31:0]            sel_a_s;
  logic                   sel_wr_s;
  logic [7:0]             sel_dout_s;
  logic                   bus_active_s;
  logic                   is_io_s;
  logic                   unused_addr_s;

  logic [READ_LATENCY-1:0]            rd_vld_q, rd_vld_d;
  logic [READ_LATENCY-1:0]            rd_io_q, rd_io_d;
  logic [READ_LATENCY-1:0][PTR_W-1:0] rd_id_q, rd_id_d;

  // First requester found scanning from ptr upward with wrap-around.
  function automatic logic [NUM_MASTERS-1:0] rr_pick(input logic [NUM_MASTERS-1:0] req,
                                                     input logic [PTR_W-1:0] ptr);
    logic [NUM_MASTERS-1:0] gnt;
    logic                   found;
    int                     idx;
    gnt   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_MASTERS) begin
        idx = idx - NUM_MASTERS;
      end else begin
        idx = idx;
      end
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end else begin
        found = found;
      end
    end
    return gnt;
  endfunction

  function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [NUM_MASTERS-1:0] oh);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      idx = idx | (PTR_W'(i) & {PTR_W{oh[i]}});
    end
    return idx;
  endfunction

  // Grant selection: debug stalls everyone, a held lock beats round-robin.
  always_comb begin
    rr_gnt_s   = rr_pick(m_req, rr_ptr_q);
    lock_hit_s = lock_valid_q & m_req[lock_owner_q];
    gnt_s      = '0;
    if (rst_in || dbg_active) begin
      gnt_s = '0;
    end else if (lock_hit_s) begin
      gnt_s[lock_owner_q] = 1'b1;
    end else begin
      gnt_s = rr_gnt_s;
    end
    gnt_idx_s = onehot_to_idx(gnt_s);
  end

  // Selected access: one-hot AND-OR mux over masters, or the debug port.
  always_comb begin
    sel_a_s    = '0;
    sel_wr_s   = 1'b0;
    sel_dout_s = '0;
    if (dbg_active) begin
      sel_a_s    = dbg_a;
      sel_wr_s   = dbg_wr;
      sel_dout_s = dbg_dout;
    end else begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        sel_a_s    = sel_a_s    | (m_a[32*i +: 32] & {32{gnt_s[i]}});
        sel_wr_s   = sel_wr_s   | (m_wr[i] & gnt_s[i]);
        sel_dout_s = sel_dout_s | (m_dout[8*i +: 8] & {8{gnt_s[i]}});
      end
    end
  end

  // Address decode and bus drive; enables are forced low while in reset.
  always_comb begin
    bus_active_s = ~rst_in & (dbg_active | (|gnt_s));
    is_io_s      = (sel_a_s[ADDR_WIDTH -: 2] == 2'b11);
    ram_en       = bus_active_s & ~is_io_s;
    io_en        = bus_active_s & is_io_s;
    ram_r_nw     = ~sel_wr_s;
    io_wr        = sel_wr_s;
    ram_a        = sel_a_s[ADDR_WIDTH-1:0];
    io_sel       = sel_a_s[IO_SEL_WIDTH-1:0];
    ram_d_out    = sel_dout_s;
    io_dout      = sel_dout_s;
    m_gnt        = gnt_s;
    dbg_din      = ram_din;
  end

  assign unused_addr_s = ^sel_a_s[31:ADDR_WIDTH+1];

  // Next state for round-robin pointer, lock tracking and the read-return pipeline.
  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    lock_owner_d = lock_owner_q;
    lock_valid_d = lock_valid_q & m_req[lock_owner_q] & m_lock[lock_owner_q];
    if (dbg_active) begin
      lock_valid_d = 1'b0;
    end else if (|gnt_s) begin
      lock_valid_d = m_lock[gnt_idx_s];
      lock_owner_d = gnt_idx_s;
      rr_ptr_d     = (gnt_idx_s == PTR_W'(NUM_MASTERS - 1)) ? '0 : gnt_idx_s + 1'b1;
    end else begin
      rr_ptr_d = rr_ptr_q;
    end

    rd_vld_d = rd_vld_q;
    rd_io_d  = rd_io_q;
    rd_id_d  = rd_id_q;
    for (int s = 1; s < READ_LATENCY; s++) begin
      rd_vld_d[s] = rd_vld_q[s-1];
      rd_io_d[s]  = rd_io_q[s-1];
      rd_id_d[s]  = rd_id_q[s-1];
    end
    // Debug accesses never grant, so they enter the pipe as empty slots.
    rd_vld_d[0] = (|gnt_s) & ~sel_wr_s;
    rd_io_d[0]  = is_io_s;
    rd_id_d[0]  = gnt_idx_s;
  end

  // State registers; reset drops any reads still in flight.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rr_ptr_q     <= '0;
      lock_owner_q <= '0;
      lock_valid_q <= 1'b0;
      rd_vld_q     <= '0;
      rd_io_q      <= '0;
      rd_id_q      <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      lock_owner_q <= lock_owner_d;
      lock_valid_q <= lock_valid_d;
      rd_vld_q     <= rd_vld_d;
      rd_io_q      <= rd_io_d;
      rd_id_q      <= rd_id_d;
    end
  end

  // Read return at the pipeline tail.
  always_comb begin
    m_rvalid = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      m_rvalid[i] = rd_vld_q[READ_LATENCY-1] & (rd_id_q[READ_LATENCY-1] == PTR_W'(i));
    end
    m_din = rd_io_q[READ_LATENCY-1] ? io_din : ram_din;
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a 2-master/latency-1 instance and a
// 3-master/latency-2 instance, each with a RAM model that returns the address LSB.
module tb_mem_bus_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Instance A: NUM_MASTERS=2, READ_LATENCY=1
  logic [1:0]  a_req, a_wr, a_lock, a_gnt, a_rvalid;
  logic [63:0] a_a;
  logic [15:0] a_dout;
  logic [7:0]  a_din, a_dbg_din, a_ram_d_out, a_ram_din, a_io_dout;
  logic        dbg_active, dbg_wr;
  logic [31:0] dbg_a;
  logic [7:0]  dbg_dout;
  logic        a_ram_en, a_ram_r_nw, a_io_en, a_io_wr;
  logic [16:0] a_ram_a;
  logic [2:0]  a_io_sel;

  mem_bus_arbiter #(.NUM_MASTERS(2), .ADDR_WIDTH(17), .IO_SEL_WIDTH(3), .READ_LATENCY(1)) u_dut (
    .clk_in(clk), .rst_in(rst),
    .m_req(a_req), .m_wr(a_wr), .m_lock(a_lock), .m_a(a_a), .m_dout(a_dout),
    .m_gnt(a_gnt), .m_rvalid(a_rvalid), .m_din(a_din),
    .dbg_active(dbg_active), .dbg_a(dbg_a), .dbg_wr(dbg_wr), .dbg_dout(dbg_dout), .dbg_din(a_dbg_din),
    .ram_en(a_ram_en), .ram_r_nw(a_ram_r_nw), .ram_a(a_ram_a), .ram_d_out(a_ram_d_out), .ram_din(a_ram_din),
    .io_en(a_io_en), .io_sel(a_io_sel), .io_wr(a_io_wr), .io_dout(a_io_dout), .io_din(8'hA5)
  );

  always @(posedge clk) a_ram_din <= a_ram_a[7:0];

  // Instance B: NUM_MASTERS=3, READ_LATENCY=2
  logic [2:0]  b_req, b_gnt, b_rvalid;
  logic [95:0] b_a;
  logic [7:0]  b_din, b_dbg_din, b_ram_d_out, b_ram_din, b_ram_p1, b_io_dout;
  logic        b_ram_en, b_ram_r_nw, b_io_en, b_io_wr;
  logic [16:0] b_ram_a;
  logic [2:0]  b_io_sel;

  mem_bus_arbiter #(.NUM_MASTERS(3), .ADDR_WIDTH(17), .IO_SEL_WIDTH(3), .READ_LATENCY(2)) u_dut3 (
    .clk_in(clk), .rst_in(rst),
    .m_req(b_req), .m_wr(3'b000), .m_lock(3'b000), .m_a(b_a), .m_dout(24'h000000),
    .m_gnt(b_gnt), .m_rvalid(b_rvalid), .m_din(b_din),
    .dbg_active(1'b0), .dbg_a(32'h0), .dbg_wr(1'b0), .dbg_dout(8'h00), .dbg_din(b_dbg_din),
    .ram_en(b_ram_en), .ram_r_nw(b_ram_r_nw), .ram_a(b_ram_a), .ram_d_out(b_ram_d_out), .ram_din(b_ram_din),
    .io_en(b_io_en), .io_sel(b_io_sel), .io_wr(b_io_wr), .io_dout(b_io_dout), .io_din(8'h5A)
  );

  always @(posedge clk) begin
    b_ram_p1  <= b_ram_a[7:0];
    b_ram_din <= b_ram_p1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    a_req = 2'b11; a_wr = 2'b00; a_lock = 2'b00; a_a = '0; a_dout = '0;
    dbg_active = 1'b0; dbg_wr = 1'b0; dbg_a = '0; dbg_dout = '0;
    b_req = 3'b000; b_a = {32'h52, 32'h51, 32'h50};
    #2;
    chk("rst_gnt", {30'd0, a_gnt}, 32'd0);
    chk("rst_ram_en", {31'd0, a_ram_en}, 32'd0);
    chk("rst_rvalid", {30'd0, a_rvalid}, 32'd0);
    a_req = 2'b00;
    tick();
    rst = 1'b0;

    // Round-robin reads, data returned one cycle after each grant
    a_req = 2'b11; a_a = {32'h20, 32'h10};
    @(negedge clk);
    chk("t1_gnt_c1", {30'd0, a_gnt}, 32'h1);
    chk("t1_ram_a_c1", {15'd0, a_ram_a}, 32'h10);
    chk("t1_ram_en_c1", {30'd0, a_ram_en, a_ram_r_nw}, 32'h3);
    chk("t1_rvalid_c1", {30'd0, a_rvalid}, 32'h0);
    tick();
    @(negedge clk);
    chk("t1_gnt_c2", {30'd0, a_gnt}, 32'h2);
    chk("t1_ram_a_c2", {15'd0, a_ram_a}, 32'h20);
    chk("t1_rvalid_c2", {30'd0, a_rvalid}, 32'h1);
    chk("t1_din_c2", {24'd0, a_din}, 32'h10);
    tick();
    @(negedge clk);
    chk("t1_gnt_c3", {30'd0, a_gnt}, 32'h1);
    chk("t1_rvalid_c3", {30'd0, a_rvalid}, 32'h2);
    chk("t1_din_c3", {24'd0, a_din}, 32'h20);
    tick();
    @(negedge clk);
    chk("t1_gnt_c4", {30'd0, a_gnt}, 32'h2);
    chk("t1_rvalid_c4", {30'd0, a_rvalid}, 32'h1);
    chk("t1_din_c4", {24'd0, a_din}, 32'h10);
    tick();
    a_req = 2'b00;
    @(negedge clk);
    chk("t1_idle_gnt", {30'd0, a_gnt}, 32'h0);
    chk("t1_idle_en", {30'd0, a_ram_en, a_io_en}, 32'h0);
    chk("t1_rvalid_c5", {30'd0, a_rvalid}, 32'h2);
    chk("t1_din_c5", {24'd0, a_din}, 32'h20);
    tick();

    // Lock: M0 alone moves the pointer to M1, then M1 holds the bus for 4 cycles
    a_req = 2'b01;
    @(negedge clk);
    chk("t2_m0_alone", {30'd0, a_gnt}, 32'h1);
    tick();
    a_req = 2'b11; a_lock = 2'b10;
    @(negedge clk);
    chk("t2_lock_c1", {30'd0, a_gnt}, 32'h2);
    chk("t2_rvalid_c1", {30'd0, a_rvalid}, 32'h1);
    tick();
    @(negedge clk);
    chk("t2_lock_c2", {30'd0, a_gnt}, 32'h2);
    tick();
    @(negedge clk);
    chk("t2_lock_c3", {30'd0, a_gnt}, 32'h2);
    tick();
    @(negedge clk);
    chk("t2_lock_c4", {30'd0, a_gnt}, 32'h2);
    tick();
    a_req = 2'b01; a_lock = 2'b00;
    @(negedge clk);
    chk("t2_release_c5", {30'd0, a_gnt}, 32'h1);
    chk("t2_rvalid_c5", {30'd0, a_rvalid}, 32'h2);
    tick();

    // IO write decode
    a_wr = 2'b01; a_a = {32'h20, 32'h0003_0004}; a_dout = 16'h0041;
    @(negedge clk);
    chk("t3_gnt", {30'd0, a_gnt}, 32'h1);
    chk("t3_en", {30'd0, a_io_en, a_ram_en}, 32'h2);
    chk("t3_io_sel", {29'd0, a_io_sel}, 32'h4);
    chk("t3_io_wr", {31'd0, a_io_wr}, 32'h1);
    chk("t3_io_dout", {24'd0, a_io_dout}, 32'h41);
    chk("t3_prev_rvalid", {30'd0, a_rvalid}, 32'h1);
    chk("t3_prev_din", {24'd0, a_din}, 32'h10);
    tick();
    a_req = 2'b00; a_wr = 2'b00;
    @(negedge clk);
    chk("t3_no_rvalid", {30'd0, a_rvalid}, 32'h0);
    tick();

    // Debug override during a lock with a read in flight
    a_req = 2'b10; a_lock = 2'b10; a_a = {32'h40, 32'h10};
    @(negedge clk);
    chk("t4_gnt_m1", {30'd0, a_gnt}, 32'h2);
    tick();
    dbg_active = 1'b1; dbg_a = 32'h0000_0123;
    @(negedge clk);
    chk("t4_dbg_gnt", {30'd0, a_gnt}, 32'h0);
    chk("t4_dbg_ram_a", {15'd0, a_ram_a}, 32'h123);
    chk("t4_dbg_ram_en", {31'd0, a_ram_en}, 32'h1);
    chk("t4_rvalid_m1", {30'd0, a_rvalid}, 32'h2);
    chk("t4_din_m1", {24'd0, a_din}, 32'h40);
    chk("t4_dbg_din", {24'd0, a_dbg_din}, 32'h40);
    tick();
    dbg_active = 1'b0; a_req = 2'b11; a_lock = 2'b00;
    @(negedge clk);
    chk("t4_lock_cleared", {30'd0, a_gnt}, 32'h1);
    chk("t4_dbg_untracked", {30'd0, a_rvalid}, 32'h0);
    tick();

    // Reset with a read in flight
    a_req = 2'b01;
    @(negedge clk);
    chk("t5_pre_gnt", {30'd0, a_gnt}, 32'h1);
    tick();
    rst = 1'b1; a_req = 2'b11;
    #1;
    chk("t5_rst_rvalid", {30'd0, a_rvalid}, 32'h0);
    chk("t5_rst_gnt", {30'd0, a_gnt}, 32'h0);
    chk("t5_rst_en", {30'd0, a_ram_en, a_io_en}, 32'h0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_first_gnt", {30'd0, a_gnt}, 32'h1);
    chk("t5_post_rvalid", {30'd0, a_rvalid}, 32'h0);
    tick();
    a_req = 2'b00;

    // Three masters, latency 2: order 2,0,1,2
    b_req = 3'b100;
    @(negedge clk);
    chk("t6_gnt_d1", {29'd0, b_gnt}, 32'h4);
    tick();
    b_req = 3'b111;
    @(negedge clk);
    chk("t6_gnt_d2", {29'd0, b_gnt}, 32'h1);
    chk("t6_rvalid_d2", {29'd0, b_rvalid}, 32'h0);
    tick();
    @(negedge clk);
    chk("t6_gnt_d3", {29'd0, b_gnt}, 32'h2);
    chk("t6_rvalid_d3", {29'd0, b_rvalid}, 32'h4);
    chk("t6_din_d3", {24'd0, b_din}, 32'h52);
    tick();
    @(negedge clk);
    chk("t6_gnt_d4", {29'd0, b_gnt}, 32'h4);
    chk("t6_rvalid_d4", {29'd0, b_rvalid}, 32'h1);
    chk("t6_din_d4", {24'd0, b_din}, 32'h50);
    tick();
    b_req = 3'b000;
    @(negedge clk);
    chk("t6_gnt_d5", {29'd0, b_gnt}, 32'h0);
    chk("t6_rvalid_d5", {29'd0, b_rvalid}, 32'h2);
    chk("t6_din_d5", {24'd0, b_din}, 32'h51);
    tick();
    @(negedge clk);
    chk("t6_rvalid_d6", {29'd0, b_rvalid}, 32'h4);
    chk("t6_din_d6", {24'd0, b_din}, 32'h52);
    tick();
    @(negedge clk);
    chk("t6_rvalid_d7", {29'd0, b_rvalid}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
